seg_scan_temp: RTL

SEG_SCAN_TEMP -- requirements
Module: seg_scan_temp

---
 rtl/seg_pkg.sv | 37 +++
 rtl/temp_bcd_conv.sv | 57 +++++
 rtl/seg_scan_temp.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and glyph table for the temperature scan display.
package seg_pkg;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  typedef enum logic [3:0] {D0, D1, D2, D3, D4, D5, D6, D7, D8, D9, MINUS, BLANK} digit_t;

  localparam int CONV_STEPS = 10;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      D0:      return GLYPH_0;
      D1:      return GLYPH_1;
      D2:      return GLYPH_2;
      D3:      return GLYPH_3;
      D4:      return GLYPH_4;
      D5:      return GLYPH_5;
      D6:      return GLYPH_6;
      D7:      return GLYPH_7;
      D8:      return GLYPH_8;
      D9:      return GLYPH_9;
      MINUS:   return GLYPH_MINUS;
      default: return GLYPH_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/temp_bcd_conv.sv
// Sign/magnitude split of an LM75A reading, then serial shift-add-3 of the
// integer and fractional parts side by side, one bit per cycle.
module temp_bcd_conv
  import seg_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [10:0]     value_i,
  output logic [2:0][3:0] int_bcd_o,
  output logic [2:0][3:0] frac_bcd_o,
  output logic            neg_o,
  output logic            done_o
);
  logic [21:0] int_q, frac_q;
  logic [3:0]  cnt_q;
  logic        busy_q, neg_q;
  logic [10:0] mag;

  // {3 BCD digits, 10-bit binary}: correct digits >= 5, then shift left
  function automatic logic [21:0] dd_step(input logic [21:0] x);
    logic [21:0] y;
    y = x;
    for (int k = 0; k < 3; k++)
      if (y[10+4*k +: 4] >= 4'd5) y[10+4*k +: 4] = y[10+4*k +: 4] + 4'd3;
    return {y[20:0], 1'b0};
  endfunction

  assign mag = value_i[10] ? (~value_i + 11'd1) : value_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_q  <= '0;
      frac_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (start_i) begin
      int_q  <= {14'd0, mag[10:3]};
      frac_q <= {12'd0, 10'(mag[2:0]) * 10'd125};
      cnt_q  <= '0;
      busy_q <= 1'b1;
      neg_q  <= value_i[10];
    end else if (busy_q) begin
      int_q  <= dd_step(int_q);
      frac_q <= dd_step(frac_q);
      cnt_q  <= cnt_q + 4'd1;
      if (cnt_q == 4'(CONV_STEPS - 1)) busy_q <= 1'b0;
    end
  end

  // high during the cycle whose closing edge performs the last shift
  assign done_o     = busy_q && (cnt_q == 4'(CONV_STEPS - 1));
  assign int_bcd_o  = int_q[21:10];
  assign frac_bcd_o = frac_q[21:10];
  assign neg_o      = neg_q;
endmodule

// File: rtl/seg_scan_temp.sv
// LM75A temperature to multiplexed 7-segment display: converter FSM, digit
// layout, scan prescaler with brightness PWM, and registered glyph outputs.
module seg_scan_temp
  import seg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int FRAC_DIGITS    = 1,
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit CS_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         data,
  input  logic                data_valid,
  input  logic [2:0]          bright,
  output logic                data_ready,
  output logic [7:0]          seg,
  output logic [N_DIGITS-1:0] cs
);
  localparam int PW        = $clog2(SCAN_DIV);
  localparam int IW        = $clog2(N_DIGITS);
  localparam int INT_SLOTS = N_DIGITS - FRAC_DIGITS;
  localparam logic [7:0]          SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIGITS-1:0] CS_OFF  = CS_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  state_t                     state_q;
  logic                       accept, conv_done, conv_neg;
  logic [2:0][3:0]            int_bcd, frac_bcd;
  logic [N_DIGITS-1:0][3:0]   disp_q, disp_d;
  logic                       ovf_q, ovf_d, dvld_q;
  logic [7:0][3:0]            ip, fp;
  int                         nint;
  logic [PW-1:0]              presc_q;
  logic [IW-1:0]              idx_q;
  logic [7:0]                 seg_q, pat;
  logic [N_DIGITS-1:0]        cs_q, sel;
  logic [35:0]                pw_lhs, pw_rhs;
  logic                       unused_data;

  assign unused_data = ^data[4:0];
  assign accept      = data_valid && (state_q == IDLE);
  assign data_ready  = (state_q == IDLE);

  temp_bcd_conv u_conv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (accept),
    .value_i    (data[15:5]),
    .int_bcd_o  (int_bcd),
    .frac_bcd_o (frac_bcd),
    .neg_o      (conv_neg),
    .done_o     (conv_done)
  );

  // Layout: fraction MSDs on the right, blanked integer, sign left of it
  always_comb begin
    ip      = '0;
    fp      = '0;
    ip[2:0] = int_bcd;
    fp[2:0] = frac_bcd;
    disp_d  = '0;
    nint    = (int_bcd[2] != 4'd0) ? 3 : (int_bcd[1] != 4'd0) ? 2 : 1;
    ovf_d   = (nint + int'(conv_neg)) > INT_SLOTS;
    for (int p = 0; p < N_DIGITS; p++) begin
      if (ovf_d)                                   disp_d[p] = MINUS;
      else if (p < FRAC_DIGITS)                    disp_d[p] = fp[3'(3 - FRAC_DIGITS + p)];
      else if (p - FRAC_DIGITS < nint)             disp_d[p] = ip[3'(p - FRAC_DIGITS)];
      else if (conv_neg && p - FRAC_DIGITS == nint) disp_d[p] = MINUS;
      else                                         disp_d[p] = BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      disp_q  <= {N_DIGITS{BLANK}};
      ovf_q   <= 1'b0;
      dvld_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_q <= CONV;
        CONV:    if (conv_done) state_q <= COMMIT;
        COMMIT: begin
          state_q <= IDLE;
          disp_q  <= disp_d;
          ovf_q   <= ovf_d;
          dvld_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // PWM compare widened so (bright+1)*SCAN_DIV never wraps
  assign pw_lhs = 36'(presc_q) << 3;
  assign pw_rhs = (36'(bright) + 36'd1) * 36'(SCAN_DIV);
  assign sel    = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;

  always_comb begin
    pat = 8'h00;
    if (dvld_q) pat = {~ovf_q && (idx_q == IW'(FRAC_DIGITS)), glyph(disp_q[idx_q])};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_OFF;
      cs_q    <= CS_OFF;
    end else begin
      if (presc_q == PW'(SCAN_DIV - 1)) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      seg_q <= SEG_ACTIVE_LOW ? ~pat : pat;
      cs_q  <= (dvld_q && (pw_lhs < pw_rhs)) ? (CS_ACTIVE_LOW ? ~sel : sel) : CS_OFF;
    end
  end

  assign seg = seg_q;
  assign cs  = cs_q;
endmodule
